// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer-facing bus of the 8-way mux arbiter: requests, grant, mux select and handshake.
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [7:0] done;
   logic [2:0] addr;
   logic       nCS;
   logic       out_valid;
   logic       out_ready;

   modport slave (
      input  req, out_ready,
      output gnt, done, addr, nCS, out_valid
   );

   modport master (
      output req, out_ready,
      input  gnt, done, addr, nCS, out_valid
   );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for an 8-input select mux with a valid/ready output handshake.
// Optional per-owner burst mode: define MUX8_ARB_BURST_EN (burst length set by BURST_LEN).
module mux8_rr_arbiter #(
   parameter int NREQ      = 8,
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   mux8_rr_arbiter_if.slave bus
);
   if (NREQ != 8) begin : g_nreq_chk
      $error("NREQ must be 8");
   end
   if (BURST_LEN < 1 || BURST_LEN > 8) begin : g_blen_chk
      $error("BURST_LEN must be in 1..8");
   end

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [2:0]      ptr, ptr_nxt, owner_nxt, pick_ptr;
   logic            rearb;
   logic [3:0]      win;
   logic            xfer;
   logic [NREQ-1:0] gnt_nxt;
   logic            ncs_nxt, ov_nxt;
`ifdef MUX8_ARB_BURST_EN
   localparam logic [2:0] BMAX = 3'(BURST_LEN - 1);
   logic [2:0]      bcnt, bcnt_nxt;
`endif

   // {found, index}: first set bit scanning upward from p, wrapping modulo 8
   function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      pick = 4'b0;
      for (int k = 7; k >= 0; k--) begin
         idx = p + 3'(k);
         if (r[idx]) pick = {1'b1, idx};
      end
   endfunction

   assign xfer     = bus.out_valid & bus.out_ready;
   assign bus.done = bus.gnt & {8{xfer & ~rst}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= 3'd0;
         bus.gnt       <= '0;
         bus.addr      <= 3'd0;
         bus.nCS       <= 1'b1;
         bus.out_valid <= 1'b0;
`ifdef MUX8_ARB_BURST_EN
         bcnt          <= 3'd0;
`endif
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         bus.gnt       <= gnt_nxt;
         bus.addr      <= owner_nxt;
         bus.nCS       <= ncs_nxt;
         bus.out_valid <= ov_nxt;
`ifdef MUX8_ARB_BURST_EN
         bcnt          <= bcnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = bus.addr;
      ptr_nxt   = ptr;
      pick_ptr  = ptr;
      rearb     = 1'b0;
      win       = 4'b0;
`ifdef MUX8_ARB_BURST_EN
      bcnt_nxt  = bcnt;
`endif
      case (state)
         IDLE: rearb = 1'b1;
         GRANT: begin
            if (xfer) begin
`ifdef MUX8_ARB_BURST_EN
               if (bus.req[bus.addr] && bcnt < BMAX) begin
                  bcnt_nxt = bcnt + 3'd1;
               end else begin
                  ptr_nxt  = bus.addr + 3'd1;
                  pick_ptr = bus.addr + 3'd1;
                  rearb    = 1'b1;
                  bcnt_nxt = 3'd0;
               end
`else
               // old owner drops to lowest priority
               ptr_nxt  = bus.addr + 3'd1;
               pick_ptr = bus.addr + 3'd1;
               rearb    = 1'b1;
`endif
            end else if (!bus.req[bus.addr]) begin
               rearb = 1'b1;
`ifdef MUX8_ARB_BURST_EN
               bcnt_nxt = 3'd0;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rearb) begin
         win = pick(bus.req, pick_ptr);
         if (win[3]) begin
            state_nxt = GRANT;
            owner_nxt = win[2:0];
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_comb begin
      gnt_nxt = '0;
      ncs_nxt = 1'b1;
      ov_nxt  = 1'b0;
      if (state_nxt == GRANT) begin
         gnt_nxt[owner_nxt] = 1'b1;
         ncs_nxt = 1'b0;
         ov_nxt  = 1'b1;
      end
   end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed bench for mux8_rr_arbiter against a spec-level arbitration model.
module tb_mux8_rr_arbiter;
   localparam int BL = 4;

   logic clk, rst;
   mux8_rr_arbiter_if bus();

   mux8_rr_arbiter #(.NREQ(8), .BURST_LEN(BL)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: who owns the mux, rotation pointer, burst count
   bit m_busy;
   int m_owner, m_ptr, m_bcnt, m_addr;

   function automatic int m_win(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++)
         if (r[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   function automatic logic [7:0] exp_gnt();
      logic [7:0] g;
      g = 8'h00;
      if (m_busy) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic logic [7:0] exp_done();
      if (rst || !m_busy || !bus.out_ready) return 8'h00;
      return exp_gnt();
   endfunction

   task automatic model_step();
      int w;
      bit burst;
`ifdef MUX8_ARB_BURST_EN
      burst = 1'b1;
`else
      burst = 1'b0;
`endif
      w = -2;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_bcnt = 0; m_addr = 0;
      end else if (!m_busy) begin
         w = m_win(bus.req, m_ptr);
      end else if (bus.out_ready) begin
         if (burst && bus.req[m_owner] && m_bcnt < BL - 1) m_bcnt++;
         else begin
            m_ptr = (m_owner + 1) % 8;
            m_bcnt = 0;
            w = m_win(bus.req, m_ptr);
         end
      end else if (!bus.req[m_owner]) begin
         m_bcnt = 0;
         w = m_win(bus.req, m_ptr);
      end
      if (w == -1) m_busy = 0;
      else if (w >= 0) begin
         m_busy = 1; m_owner = w; m_addr = w;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.req = 8'hFF; bus.out_ready = 1'b0;
      cyc(); cyc();
      checks++;
      if (bus.gnt !== 8'h00 || bus.nCS !== 1'b1 || bus.out_valid !== 1'b0 || bus.addr !== 3'd0) begin
         errors++;
         $display("FAIL reset_vals gnt=%h nCS=%b ov=%b addr=%0d want 00/1/0/0", bus.gnt, bus.nCS, bus.out_valid, bus.addr);
      end
      checks++;
      if (bus.done !== 8'h00) begin
         errors++; $display("FAIL reset_done done=%h want 00", bus.done);
      end
      rst = 1'b0;
      cyc();
      checks++;
      if (bus.gnt !== 8'h01 || bus.addr !== 3'd0 || bus.nCS !== 1'b0 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_grant gnt=%h addr=%0d nCS=%b ov=%b want 01/0/0/1", bus.gnt, bus.addr, bus.nCS, bus.out_valid);
      end
   endtask

   task automatic test_single();
      int n;
      do_reset();
      bus.req = 8'h20; bus.out_ready = 1'b1;
      cyc();
      n = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bus.done !== 8'h20) begin
            errors++; $display("FAIL single_done[%0d] done=%h want 20", i, bus.done);
         end else n++;
         cyc();
         checks++;
         if (bus.addr !== 3'd5 || bus.nCS !== 1'b0 || bus.gnt !== 8'h20) begin
            errors++; $display("FAIL single_hold[%0d] addr=%0d nCS=%b gnt=%h want 5/0/20", i, bus.addr, bus.nCS, bus.gnt);
         end
      end
      checks++;
      if (n != 4) begin
         errors++; $display("FAIL single_count transfers=%0d want 4", n);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] oh;
      do_reset();
      bus.req = 8'hFF; bus.out_ready = 1'b1;
      cyc();
      checks++;
      if (bus.addr !== 3'd0) begin
         errors++; $display("FAIL rr_first addr=%0d want 0", bus.addr);
      end
      for (int i = 0; i < 8; i++) begin
         #1;
         oh = 8'h00; oh[i] = 1'b1;
         checks++;
         if (bus.done !== oh || bus.done !== bus.gnt) begin
            errors++; $display("FAIL rr_done[%0d] done=%h gnt=%h want %h", i, bus.done, bus.gnt, oh);
         end
         cyc();
         checks++;
         if (bus.addr !== 3'((i + 1) % 8)) begin
            errors++; $display("FAIL rr_addr[%0d] addr=%0d want %0d", i, bus.addr, (i + 1) % 8);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      bus.req = 8'h08; bus.out_ready = 1'b0;
      cyc();
      bus.req = 8'hF8;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.done !== 8'h00) begin
            errors++; $display("FAIL stall_done[%0d] done=%h want 00", i, bus.done);
         end
         cyc();
         checks++;
         if (bus.gnt !== 8'h08 || bus.addr !== 3'd3 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold[%0d] gnt=%h addr=%0d ov=%b want 08/3/1", i, bus.gnt, bus.addr, bus.out_valid);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.done !== 8'h08) begin
         errors++; $display("FAIL stall_release_done done=%h want 08", bus.done);
      end
      cyc();
      checks++;
      if (bus.gnt !== 8'h10 || bus.addr !== 3'd4) begin
         errors++; $display("FAIL stall_next gnt=%h addr=%0d want 10/4", bus.gnt, bus.addr);
      end
   endtask

   task automatic test_abort();
      do_reset();
      bus.req = 8'h04; bus.out_ready = 1'b0;
      cyc();
      bus.req = 8'h44;
      cyc();
      bus.req = 8'h40;
      #1;
      checks++;
      if (bus.done !== 8'h00) begin
         errors++; $display("FAIL abort_done done=%h want 00", bus.done);
      end
      cyc();
      checks++;
      if (bus.gnt !== 8'h40 || bus.addr !== 3'd6 || bus.nCS !== 1'b0) begin
         errors++; $display("FAIL abort_regrant gnt=%h addr=%0d nCS=%b want 40/6/0", bus.gnt, bus.addr, bus.nCS);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (bus.gnt !== 8'h00 || bus.nCS !== 1'b1 || bus.out_valid !== 1'b0 || bus.addr !== 3'd0) begin
         errors++;
         $display("FAIL midgrant_reset gnt=%h nCS=%b ov=%b addr=%0d want 00/1/0/0", bus.gnt, bus.nCS, bus.out_valid, bus.addr);
      end
   endtask

`ifdef MUX8_ARB_BURST_EN
   task automatic test_burst();
      int seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      do_reset();
      bus.req = 8'h03; bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         checks++;
         if (bus.addr !== 3'(seq[i])) begin
            errors++; $display("FAIL burst_addr[%0d] addr=%0d want %0d", i, bus.addr, seq[i]);
         end
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         bus.req = ($urandom_range(0, 1) == 0) ? 8'($urandom & $urandom) : 8'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 59) == 0);
         #1;
         checks++;
         if (bus.done !== exp_done()) begin
            errors++; $display("FAIL rand_done[%0d] done=%h want %h", i, bus.done, exp_done());
         end
         cyc();
         checks++;
         if (bus.gnt !== exp_gnt() || bus.addr !== 3'(m_addr) || bus.nCS !== !m_busy || bus.out_valid !== m_busy) begin
            errors++;
            $display("FAIL rand_out[%0d] gnt=%h addr=%0d nCS=%b ov=%b want %h/%0d/%b/%b",
                     i, bus.gnt, bus.addr, bus.nCS, bus.out_valid, exp_gnt(), m_addr, !m_busy, m_busy);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus.req = 8'h00; bus.out_ready = 1'b0;
      m_busy = 0; m_owner = 0; m_ptr = 0; m_bcnt = 0; m_addr = 0;
      test_reset();
`ifndef MUX8_ARB_BURST_EN
      test_single();
      test_round_robin();
      test_stall();
`else
      test_burst();
`endif
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
